// File: rtl/texture_mapper_mult_arbiter_if.sv
// Request/response bundle between texture-mapper units and the shared multiplier.
// The arbiter takes the slave side; requesters (or a bench) drive the master side.
interface texture_mapper_mult_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int WIDTHA  = 32,
   parameter int WIDTHB  = 32,
   parameter int WIDTHP  = 64,
   parameter int PIPE    = 2
);
   logic [NUM_REQ-1:0]          req_valid;
   logic [NUM_REQ-1:0]          req_ready;
   logic [NUM_REQ*WIDTHA-1:0]   req_dataa;
   logic [NUM_REQ*WIDTHB-1:0]   req_datab;
   logic [NUM_REQ-1:0]          resp_valid;
   logic [WIDTHP-1:0]           resp_result;
   logic [$clog2(PIPE+3)-1:0]   inflight;

   modport master (
      output req_valid, req_dataa, req_datab,
      input  req_ready, resp_valid, resp_result, inflight
   );

   modport slave (
      input  req_valid, req_dataa, req_datab,
      output req_ready, resp_valid, resp_result, inflight
   );
endinterface

// File: rtl/texture_mapper_mult_arbiter.sv
// Round-robin arbiter sharing one pipelined multiplier among NUM_REQ texture-mapper units.
// Products return on the issuing requester's strobe after a fixed PIPE+1 cycle latency.
module texture_mapper_mult_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTHA  = 32,
   parameter int WIDTHB  = 32,
   parameter int WIDTHP  = 64,
   parameter int SIGNED  = 0,
   parameter int PIPE    = 2
) (
   input logic                          clk,
   input logic                          reset,
   texture_mapper_mult_arbiter_if.slave io_bus
);
   localparam int TAG_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(PIPE + 3);
   localparam int XW    = (WIDTHA + WIDTHB > WIDTHP) ? (WIDTHA + WIDTHB) : WIDTHP;

   // Extend both operands to XW bits so the low WIDTHP bits are exact in either mode.
   function automatic logic [WIDTHP-1:0] mul_trunc(input logic [WIDTHA-1:0] a,
                                                  input logic [WIDTHB-1:0] b);
      logic                 a_sx;
      logic                 b_sx;
      logic signed [XW-1:0] ea;
      logic signed [XW-1:0] eb;
      logic signed [XW-1:0] pr;
      a_sx = (SIGNED != 0) && a[WIDTHA-1];
      b_sx = (SIGNED != 0) && b[WIDTHB-1];
      ea   = $signed({{(XW-WIDTHA){a_sx}}, a});
      eb   = $signed({{(XW-WIDTHB){b_sx}}, b});
      pr   = ea * eb;
      return pr[WIDTHP-1:0];
   endfunction

   logic [TAG_W-1:0]  r_ptr;
   logic [NUM_REQ-1:0] w_grant;
   logic [TAG_W-1:0]  w_gidx;
   logic              w_found;
   logic              w_accept;
   logic              w_resp;

   logic              r_vld_p0;
   logic [TAG_W-1:0]  r_tag_p0;
   logic [WIDTHA-1:0] r_a_p0;
   logic [WIDTHB-1:0] r_b_p0;
   logic [WIDTHP-1:0] w_prod_p0;

   logic [PIPE-1:0]   r_vld_pk;
   logic [TAG_W-1:0]  r_tag_pk  [PIPE];
   logic [WIDTHP-1:0] r_prod_pk [PIPE];

   logic [CNT_W-1:0]  r_inflight;

   // Search upward from the pointer; reset masks the grant so nothing is accepted.
   always_comb begin
      w_found = 1'b0;
      w_gidx  = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!w_found && io_bus.req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
            w_found = 1'b1;
            w_gidx  = TAG_W'((int'(r_ptr) + k) % NUM_REQ);
         end
      end
      w_accept = w_found && !reset;
      w_grant  = '0;
      if (w_accept) w_grant[w_gidx] = 1'b1;
   end

   assign io_bus.req_ready = w_grant;

   always_ff @(posedge clk) begin
      if (reset)
         r_ptr <= '0;
      else if (w_accept)
         r_ptr <= (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + 1'b1;
   end

   // ---- stage p0: operand capture ----
   always_ff @(posedge clk) begin
      if (reset) r_vld_p0 <= 1'b0;
      else       r_vld_p0 <= w_accept;
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_tag_p0 <= w_gidx;
         r_a_p0   <= io_bus.req_dataa[w_gidx*WIDTHA +: WIDTHA];
         r_b_p0   <= io_bus.req_datab[w_gidx*WIDTHB +: WIDTHB];
      end
   end

   assign w_prod_p0 = mul_trunc(r_a_p0, r_b_p0);

   // ---- stages p1..pPIPE: product pipeline ----
   always_ff @(posedge clk) begin
      if (reset) begin
         r_vld_pk <= '0;
      end else begin
         r_vld_pk[0] <= r_vld_p0;
         for (int k = 1; k < PIPE; k++) r_vld_pk[k] <= r_vld_pk[k-1];
      end
   end

   // Only the final stage is cleared, since it is the visible resp_result.
   always_ff @(posedge clk) begin
      if (r_vld_p0) begin
         r_tag_pk[0]  <= r_tag_p0;
         r_prod_pk[0] <= w_prod_p0;
      end
      for (int k = 1; k < PIPE; k++) begin
         if (r_vld_pk[k-1]) begin
            r_tag_pk[k]  <= r_tag_pk[k-1];
            r_prod_pk[k] <= r_prod_pk[k-1];
         end
      end
      if (reset) r_prod_pk[PIPE-1] <= '0;
   end

   assign w_resp             = r_vld_pk[PIPE-1];
   assign io_bus.resp_result = r_prod_pk[PIPE-1];

   always_comb begin
      io_bus.resp_valid = '0;
      if (w_resp) io_bus.resp_valid[r_tag_pk[PIPE-1]] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset)
         r_inflight <= '0;
      else if (w_accept && !w_resp)
         r_inflight <= r_inflight + 1'b1;
      else if (!w_accept && w_resp)
         r_inflight <= r_inflight - 1'b1;
   end

   assign io_bus.inflight = r_inflight;
endmodule

// File: tb/tb_texture_mapper_mult_arbiter.sv
// Directed bench for the shared multiplier arbiter: grant order, result scoreboard,
// inflight tracking, reset flush and signed/unsigned arithmetic.
module tb_texture_mapper_mult_arbiter;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;
   int   cyc;
   int   peak;

   typedef struct {
      int          due;
      logic [3:0]  vld;
      logic [63:0] res;
   } sb_t;
   sb_t sb[$];

   logic [31:0] da [4];
   logic [31:0] db [4];

   texture_mapper_mult_arbiter_if #(.NUM_REQ(4), .WIDTHA(32), .WIDTHB(32), .WIDTHP(64), .PIPE(2)) bus ();
   texture_mapper_mult_arbiter_if #(.NUM_REQ(4), .WIDTHA(32), .WIDTHB(32), .WIDTHP(64), .PIPE(2)) bus2 ();

   texture_mapper_mult_arbiter #(
      .NUM_REQ(4), .WIDTHA(32), .WIDTHB(32), .WIDTHP(64), .SIGNED(0), .PIPE(2)
   ) u_dut (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus)
   );

   texture_mapper_mult_arbiter #(
      .NUM_REQ(4), .WIDTHA(32), .WIDTHB(32), .WIDTHP(64), .SIGNED(1), .PIPE(2)
   ) u_sgn (
      .clk    (clk),
      .reset  (reset),
      .io_bus (bus2)
   );

   assign bus.req_dataa = {da[3], da[2], da[1], da[0]};
   assign bus.req_datab = {db[3], db[2], db[1], db[0]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: check outputs at the falling edge, record the expected response.
   task automatic step(input logic [3:0] exp_rdy);
      int g;
      @(negedge clk);
      if (int'(bus.inflight) > peak) peak = int'(bus.inflight);
      chk("inflight", 64'(bus.inflight), 64'(sb.size()));
      chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
      if (sb.size() > 0 && sb[0].due == cyc) begin
         chk("resp_valid", 64'(bus.resp_valid), 64'(sb[0].vld));
         chk("resp_result", bus.resp_result, sb[0].res);
         void'(sb.pop_front());
      end else begin
         chk("resp_idle", 64'(bus.resp_valid), 64'd0);
      end
      if (exp_rdy != 4'b0000 && !reset) begin
         g = 0;
         for (int i = 0; i < 4; i++) if (exp_rdy[i]) g = i;
         sb.push_back('{due: cyc + 3, vld: exp_rdy, res: 64'(da[g]) * 64'(db[g])});
      end
      @(posedge clk);
      if (reset) sb.delete();
      cyc++;
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      cyc   = 0;
      peak  = 0;
      for (int i = 0; i < 4; i++) begin
         da[i] = '0;
         db[i] = '0;
      end
      bus2.req_valid = '0;
      bus2.req_dataa = '0;
      bus2.req_datab = '0;
      reset          = 1'b1;
      bus.req_valid  = 4'b1111;

      // Reset state with every requester asking
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_ready", 64'(bus.req_ready), 64'd0);
      chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
      chk("rst_resp_result", bus.resp_result, 64'd0);
      chk("rst_inflight", 64'(bus.inflight), 64'd0);
      @(posedge clk);
      #1;
      reset         = 1'b0;
      bus.req_valid = 4'b0000;

      // Requester 1 alone: 7*6
      da[1] = 32'd7; db[1] = 32'd6;
      bus.req_valid = 4'b0010;
      step(4'b0010);
      bus.req_valid = 4'b0000;
      repeat (4) step(4'b0000);

      // Requester 2 alone, back-to-back for 5 cycles
      peak = 0;
      bus.req_valid = 4'b0100;
      for (int n = 0; n < 5; n++) begin
         da[2] = 32'd100 + 32'(n);
         db[2] = 32'd3 + 32'(n);
         step(4'b0100);
      end
      bus.req_valid = 4'b0000;
      repeat (4) step(4'b0000);
      chk("inflight_peak", 64'(peak), 64'd3);

      // Pointer at 3, only 0 and 2 requesting: alternate starting with 0
      da[0] = 32'd11; db[0] = 32'd12;
      da[2] = 32'd13; db[2] = 32'd14;
      bus.req_valid = 4'b0101;
      step(4'b0001);
      step(4'b0100);
      step(4'b0001);
      step(4'b0100);
      bus.req_valid = 4'b0000;
      repeat (4) step(4'b0000);

      // Signed vs unsigned on -3 * 5
      da[0] = 32'hFFFF_FFFD; db[0] = 32'd5;
      bus.req_valid  = 4'b0001;
      bus2.req_valid = 4'b0001;
      bus2.req_dataa = {96'd0, 32'hFFFF_FFFD};
      bus2.req_datab = {96'd0, 32'd5};
      step(4'b0001);
      bus.req_valid  = 4'b0000;
      bus2.req_valid = 4'b0000;
      step(4'b0000);
      step(4'b0000);
      chk("sgn_resp_valid", 64'(bus2.resp_valid), 64'h1);
      chk("sgn_resp_result", bus2.resp_result, 64'hFFFF_FFFF_FFFF_FFF1);
      chk("uns_resp_result", bus.resp_result, 64'h0000_0004_FFFF_FFF1);
      repeat (3) step(4'b0000);

      // Three accepts, then reset one cycle later drops what is still in flight
      bus.req_valid = 4'b0010;
      for (int n = 0; n < 3; n++) begin
         da[1] = 32'd50 + 32'(n);
         db[1] = 32'd2;
         step(4'b0010);
      end
      bus.req_valid = 4'b0000;
      step(4'b0000);
      reset         = 1'b1;
      bus.req_valid = 4'b1111;
      step(4'b0000);
      reset = 1'b0;

      // All four continuously from a fresh pointer: 0,1,2,3,0,1,2,3
      for (int i = 0; i < 4; i++) begin
         da[i] = 32'(i + 1);
         db[i] = 32'd10;
      end
      for (int r = 0; r < 2; r++) begin
         step(4'b0001);
         step(4'b0010);
         step(4'b0100);
         step(4'b1000);
      end
      bus.req_valid = 4'b0000;
      repeat (4) step(4'b0000);
      chk("final_inflight", 64'(bus.inflight), 64'd0);
      chk("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
